// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin grant sequencer.
// The width is fixed at 8 requesters to match the downstream 3-to-8 decoder.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  function automatic logic [N_REQ-1:0] idx_onehot(input idx_t i);
    idx_onehot = '0;
    idx_onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_grant_sequencer_pick.sv
// Circular first-one finder: scans vec starting at start, wrapping modulo N_REQ.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  idx_t             start,
  output idx_t             idx,
  output logic             found
);

  idx_t pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = start + IDX_W'(i);
      if (!found && vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter over 8 requesters with grant hold and optional hold timeout.
// grant_idx / grant_valid are registered and drive the decoder select / enable.
module rr_grant_sequencer
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic [IDX_W-1:0] ptr_dbg
);

  localparam int                CNT_W     = $clog2(MAX_HOLD) + 1;
  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

  arb_state_t       state;
  idx_t             ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [N_REQ-1:0] pick_vec;
  idx_t             pick_start;
  idx_t             pick_idx;
  logic             pick_found;
  idx_t             next_idx;
  logic             owner_req;
  logic             timeout_hit;

  assign next_idx  = grant_idx + IDX_W'(1);
  assign owner_req = req[grant_idx];

  // While granted, the owner is masked out and the scan starts just past it, so
  // one finder serves both the release handoff and the forced rotation.
  always_comb begin
    pick_vec   = req;
    pick_start = ptr;
    if (state == GRANT) begin
      pick_vec   = req & ~idx_onehot(grant_idx);
      pick_start = next_idx;
    end
  end

  rr_pick u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign timeout_hit = HOLD_EN && (hold_cnt == HOLD_LAST) && pick_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            ptr      <= next_idx;
            hold_cnt <= '0;
            if (pick_found) begin
              grant_idx <= pick_idx;
            end else begin
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end else if (timeout_hit) begin
            grant_idx <= pick_idx;
            ptr       <= next_idx;
            hold_cnt  <= '0;
          end else if (HOLD_EN && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ptr_dbg = ptr;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer built with MAX_HOLD=4.
module tb_rr_grant_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [2:0] ptr_dbg;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [7:0] req;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic [2:0] exp_ptr;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];

  rr_grant_sequencer #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .ptr_dbg     (ptr_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] r, input logic v, input logic [2:0] i, input logic [2:0] p);
    vec_t e;
    e.req = r; e.exp_valid = v; e.exp_idx = i; e.exp_ptr = p;
    vecs.push_back(e);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    req   = 8'hFF;

    // reset holds everything at zero even with all requests up
    repeat (2) step();
    check("reset_valid", {7'd0, grant_valid}, 8'd0);
    check("reset_idx", {5'd0, grant_idx}, 8'd0);
    check("reset_ptr", {5'd0, ptr_dbg}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // req applied before the edge, expected outputs after it
    add(8'hFF, 1, 0, 0);  // first grant, one cycle latency
    add(8'h05, 1, 0, 0);
    add(8'h05, 1, 0, 0);
    add(8'h04, 1, 2, 1);  // owner 0 drops: handoff to 2 on the same edge
    add(8'h00, 0, 2, 3);
    add(8'h40, 1, 6, 3);
    add(8'h81, 1, 7, 7);  // 6 releases, ptr=7, pick 7
    add(8'h01, 1, 0, 0);  // 7 releases, wrap to 0
    add(8'h00, 0, 0, 1);
    add(8'h12, 1, 1, 1);  // timeout rotation 1,1,1,1,4,4,4,4,1
    add(8'h12, 1, 1, 1);
    add(8'h12, 1, 1, 1);
    add(8'h12, 1, 1, 1);
    add(8'h12, 1, 4, 2);
    add(8'h12, 1, 4, 2);
    add(8'h12, 1, 4, 2);
    add(8'h12, 1, 4, 2);
    add(8'h12, 1, 1, 5);
    add(8'h12, 1, 1, 5);
    add(8'h12, 1, 1, 5);
    add(8'h12, 1, 1, 5);
    add(8'h10, 1, 4, 2);  // release coinciding with timeout
    add(8'h10, 1, 4, 2);
    add(8'h1F, 1, 4, 2);  // late arrivals do not pre-empt
    add(8'h1F, 1, 4, 2);
    add(8'h1F, 1, 0, 5);  // timeout with 4 masked, scan 5.. wraps to 0
    add(8'h00, 0, 0, 1);

    foreach (vecs[k]) begin
      req = vecs[k].req;
      step();
      check($sformatf("vec%0d_valid", k), {7'd0, grant_valid}, {7'd0, vecs[k].exp_valid});
      check($sformatf("vec%0d_idx", k), {5'd0, grant_idx}, {5'd0, vecs[k].exp_idx});
      check($sformatf("vec%0d_ptr", k), {5'd0, ptr_dbg}, {5'd0, vecs[k].exp_ptr});
    end

    // sole requester never loses the grant despite the timeout
    req = 8'h20;
    for (int c = 0; c < 20; c++) exp_q.push_back(3'd5);
    while (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      step();
      check("sole_valid", {7'd0, grant_valid}, 8'd1);
      check("sole_idx", {5'd0, grant_idx}, {5'd0, e});
    end
    check("sole_ptr", {5'd0, ptr_dbg}, 8'd1);

    // async reset between edges drops the grant immediately
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_valid", {7'd0, grant_valid}, 8'd0);
    check("async_idx", {5'd0, grant_idx}, 8'd0);
    check("async_ptr", {5'd0, ptr_dbg}, 8'd0);
    check("async_clk_low", {7'd0, clk}, 8'd0);

    req = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_reset_valid", {7'd0, grant_valid}, 8'd1);
    check("post_reset_idx", {5'd0, grant_idx}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
